// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 DIT FFT sequencer: butterfly read issue, write-back address pipe, bit-reversed unload.
// Latency: read pair -> write-back exactly PIPE_LAT cycles; first read pair the cycle after start.
// Backpressure: rd_ready / out_ready stall the issue side only; in-flight write-backs never stall.
module fft_seq_ctrl #(
  parameter int LOG2_MAX = 10,
  parameter int PIPE_LAT = 4,
  parameter int CNT_W    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [3:0]            i_cfg_log2n,
  input  logic                  i_cfg_inverse,
  output logic                  o_busy,
  output logic                  o_cfg_err,
  output logic [3:0]            o_stage,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [LOG2_MAX-1:0]   o_rd_addr_a,
  output logic [LOG2_MAX-1:0]   o_rd_addr_b,
  output logic [LOG2_MAX-2:0]   o_tw_idx,
  output logic                  o_tw_conj,
  output logic                  o_wr_en,
  output logic [LOG2_MAX-1:0]   o_wr_addr_a,
  output logic [LOG2_MAX-1:0]   o_wr_addr_b,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [LOG2_MAX-1:0]   o_out_addr,
  output logic                  o_out_last,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_cycle_cnt
);

  localparam int AW   = LOG2_MAX;
  localparam int TW_W = LOG2_MAX - 1;
  localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [AW-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BFLY   = 3'd1,
    S_DRAIN  = 3'd2,
    S_UNLOAD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [3:0]         r_log2n;
  logic               r_inv;
  logic [3:0]         r_s;
  logic [AW-1:0]      r_j;
  logic [AW-1:0]      r_idx;
  logic [DW-1:0]      r_drain;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cfg_err;

  logic [AW-1:0]      r_rd_addr_a;
  logic [AW-1:0]      r_rd_addr_b;
  logic [TW_W-1:0]    r_tw_idx;
  logic [AW-1:0]      r_out_addr;
  logic               r_out_last;

  logic [PIPE_LAT-1:0] r_pv;
  logic [AW-1:0]      r_pa [PIPE_LAT];
  logic [AW-1:0]      r_pb [PIPE_LAT];

  logic               w_cfg_ok;
  logic               w_go;
  logic               w_rd_fire;
  logic               w_out_fire;
  logic [AW-1:0]      w_jmax;
  logic [AW-1:0]      w_nm1;
  logic               w_j_last;
  logic               w_idx_last;
  logic               w_drain_end;
  logic               w_s_last;

  logic [3:0]         w_s_nxt;
  logic [AW-1:0]      w_j_nxt;
  logic [AW-1:0]      w_idx_nxt;
  logic [DW-1:0]      w_drain_nxt;

  logic [AW-1:0]      w_mask;
  logic [AW-1:0]      w_half;
  logic [AW-1:0]      w_a_nxt;
  logic [AW-1:0]      w_b_nxt;
  logic [TW_W-1:0]    w_tw_nxt;

  // Reverse the low n bits of v; bits above n come out as zero because v < 2^n.
  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] v, input logic [3:0] n);
    logic [AW-1:0] rev;
    rev = '0;
    for (int i = 0; i < AW; i++) rev[i] = v[AW-1-i];
    return rev >> (4'(AW) - n);
  endfunction

  // Handshake qualifiers and end-of-loop detection; abort suppresses any transfer in its cycle.
  always_comb begin
    w_cfg_ok    = (i_cfg_log2n != 4'd0) && (int'(i_cfg_log2n) <= LOG2_MAX);
    w_go        = (r_state == S_IDLE) && i_start && w_cfg_ok && !i_abort;
    w_rd_fire   = (r_state == S_BFLY) && i_rd_ready && !i_abort;
    w_out_fire  = (r_state == S_UNLOAD) && i_out_ready && !i_abort;
    // N/2-1 and N-1; for N = 2^AW the shift wraps to 0 and the subtraction yields all-ones.
    w_jmax      = (ONE << (r_log2n - 4'd1)) - ONE;
    w_nm1       = (ONE << r_log2n) - ONE;
    w_j_last    = (r_j == w_jmax);
    w_idx_last  = (r_idx == w_nm1);
    w_drain_end = (r_drain == DW'(PIPE_LAT - 1));
    w_s_last    = (r_s == r_log2n);
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start && w_cfg_ok) w_state_nxt = S_BFLY;
      S_BFLY:   if (w_rd_fire && w_j_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_drain_end) w_state_nxt = w_s_last ? S_UNLOAD : S_BFLY;
      S_UNLOAD: if (w_out_fire && w_idx_last) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  // FSM output decode from the state register.
  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_rd_valid  = (r_state == S_BFLY);
    o_tw_conj   = (r_state == S_BFLY) && r_inv;
    o_out_valid = (r_state == S_UNLOAD);
    o_done      = (r_state == S_DONE);
    o_stage     = (r_state == S_IDLE) ? 4'd0 : r_s;
  end

  // Next values of the stage / butterfly / unload / drain counters.
  always_comb begin
    w_s_nxt     = r_s;
    w_j_nxt     = r_j;
    w_idx_nxt   = r_idx;
    w_drain_nxt = r_drain;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_s_nxt   = 4'd1;
          w_j_nxt   = '0;
          w_idx_nxt = '0;
        end
      end
      S_BFLY: begin
        w_drain_nxt = '0;
        if (w_rd_fire) w_j_nxt = w_j_last ? '0 : r_j + ONE;
      end
      S_DRAIN: begin
        w_drain_nxt = r_drain + DW'(1);
        if (w_drain_end) begin
          w_drain_nxt = '0;
          if (!w_s_last) begin
            w_s_nxt = r_s + 4'd1;
            w_j_nxt = '0;
          end else begin
            w_idx_nxt = '0;
          end
        end
      end
      S_UNLOAD: if (w_out_fire) w_idx_nxt = r_idx + ONE;
      default: ;
    endcase
  end

  // Butterfly geometry for the next cycle: a = (g<<s)+k is j with a zero inserted at bit s-1.
  always_comb begin
    w_mask   = (ONE << (w_s_nxt - 4'd1)) - ONE;
    w_half   = ONE << (w_s_nxt - 4'd1);
    w_a_nxt  = ((w_j_nxt & ~w_mask) << 1) | (w_j_nxt & w_mask);
    w_b_nxt  = w_a_nxt | w_half;
    w_tw_nxt = TW_W'((w_j_nxt & w_mask) << (4'(LOG2_MAX) - w_s_nxt));
  end

  // Counters and latched configuration.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s     <= '0;
      r_j     <= '0;
      r_idx   <= '0;
      r_drain <= '0;
      r_log2n <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_s     <= w_s_nxt;
      r_j     <= w_j_nxt;
      r_idx   <= w_idx_nxt;
      r_drain <= w_drain_nxt;
      if (w_go) begin
        r_log2n <= i_cfg_log2n;
        r_inv   <= i_cfg_inverse;
      end
    end
  end

  // Registered address outputs, zero whenever the matching valid will be low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_idx    <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_rd_addr_a <= (w_state_nxt == S_BFLY) ? w_a_nxt : '0;
      r_rd_addr_b <= (w_state_nxt == S_BFLY) ? w_b_nxt : '0;
      r_tw_idx    <= (w_state_nxt == S_BFLY) ? w_tw_nxt : '0;
      r_out_addr  <= (w_state_nxt == S_UNLOAD) ? f_bitrev(w_idx_nxt, r_log2n) : '0;
      r_out_last  <= (w_state_nxt == S_UNLOAD) && (w_idx_nxt == w_nm1);
    end
  end

  // Write-back delay line: accepted pairs emerge exactly PIPE_LAT cycles later; abort discards them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_fire;
      r_pa[0] <= r_rd_addr_a;
      r_pb[0] <= r_rd_addr_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
      if (i_abort) r_pv <= '0;
    end
  end

  // Busy-cycle counter: cleared on a run start, saturating, frozen in IDLE; config error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) && i_start && !i_abort && !w_cfg_ok;
      if (r_state == S_IDLE) begin
        if (w_go) r_cnt <= '0;
      end else if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cfg_err   = r_cfg_err;
  assign o_rd_addr_a = r_rd_addr_a;
  assign o_rd_addr_b = r_rd_addr_b;
  assign o_tw_idx    = r_tw_idx;
  assign o_wr_en     = r_pv[PIPE_LAT-1];
  assign o_wr_addr_a = r_pa[PIPE_LAT-1];
  assign o_wr_addr_b = r_pb[PIPE_LAT-1];
  assign o_out_addr  = r_out_addr;
  assign o_out_last  = r_out_last;
  assign o_cycle_cnt = r_cnt;

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Next-generation in-place radix-2 DIT FFT sequencer.
- Run-time FFT length from 2^1 to 2^LOG2_MAX points.
- Inverse-transform flag.
- Ready/valid handshake on the read-issue side.
- Fixed-latency write-back address pipeline with per-stage drain, replacing the fixed two-cycle DELAY scheme.
- Bit-reversed unload phase with handshake.
- Sits between the ping memory, the butterfly/CORDIC twiddle unit and the output stream interface.

Parameters:
- LOG2_MAX, 10, log2 of maximum FFT length; address width AW = LOG2_MAX.
- PIPE_LAT, 4, cycles from an accepted read pair to its write-back (memory read plus butterfly), must be >= 1.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a transform, sampled in IDLE only
- abort  in  1  synchronous abort, returns to IDLE next cycle
- cfg_log2n  in  4  log2 of transform length, latched at start
- cfg_inverse  in  1  1 = IFFT, latched at start
- busy  out  1  high in every state except IDLE
- cfg_err  out  1  one-cycle pulse when start is seen with an illegal cfg_log2n
- stage  out  4  current stage 1..log2n; 0 in IDLE
- rd_valid  out  1  a butterfly read pair is presented
- rd_ready  in  1  memory/butterfly accepts the pair
- rd_addr_a  out  AW  top input address
- rd_addr_b  out  AW  bottom input address
- tw_idx  out  LOG2_MAX-1  twiddle index into the N_max/2 table
- tw_conj  out  1  = latched cfg_inverse while rd_valid
- wr_en  out  1  write-back strobe for a result pair
- wr_addr_a  out  AW  write-back top address
- wr_addr_b  out  AW  write-back bottom address
- out_valid  out  1  unload address valid
- out_ready  in  1  downstream accepts the unload word
- out_addr  out  AW  bit-reversed read address for unload
- out_last  out  1  marks the final unload word
- done  out  1  one-cycle completion pulse
- cycle_cnt  out  CNT_W  cycles spent in non-IDLE states of the last/current run

Behaviour:
Reset:
- State goes to IDLE.
- All outputs go to 0.
- The write-back pipeline is flushed, so no wr_en follows reset.
- cycle_cnt clears to 0.

States and transitions:
- IDLE -> BFLY on start when 1 <= cfg_log2n <= LOG2_MAX.
  - On entry: cfg is latched, stage=1, j=0, cycle_cnt=0.
  - An illegal cfg_log2n pulses cfg_err and the block stays in IDLE.
  - start is ignored while busy.
- BFLY: rd_valid=1.
  - Butterfly index j runs 0..N/2-1, with half=2^(s-1), g=j>>(s-1), k=j&(half-1).
  - rd_addr_a=(g<<s)+k, rd_addr_b=rd_addr_a+half, tw_idx=k<<(LOG2_MAX-s).
  - All outputs are registered and hold stable while rd_ready=0.
  - j advances only on rd_valid&&rd_ready.
  - After the transfer with j=N/2-1, go to DRAIN.
- DRAIN: rd_valid=0 for exactly PIPE_LAT cycles.
  - Then, if s<log2n: s++, j=0, back to BFLY.
  - Otherwise go to UNLOAD.
  - The next stage never reads a location before its write-back.
- UNLOAD: out_valid=1, out_addr=bitrev_log2n(idx).
  - Only the low log2n bits are reversed; upper address bits are 0.
  - idx 0..N-1 advances on out_valid&&out_ready.
  - out_last=1 when idx=N-1; that transfer goes to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 from IDLE.

Write-back pipeline:
- Every accepted read pair is pushed into a PIPE_LAT-deep shift register.
- Exactly PIPE_LAT cycles later it appears as wr_en=1 with the same addresses.
- The pipeline never stalls; rd_ready has no effect on pairs already in flight.

cycle_cnt:
- Increments every cycle while busy, including DONE.
- Holds its value in IDLE.
- Saturates at all-ones.

abort:
- Takes priority over all transitions.
- Next cycle: state IDLE, stage=0, all valids 0, in-flight write-backs discarded, no done pulse.
- cycle_cnt holds its value.

Other rules:
- abort and start in the same IDLE cycle: abort wins, no run starts.
- Reset mid-run behaves exactly like abort but also clears cycle_cnt.
- log2n=1: a single stage with one butterfly (0,1), tw_idx=0.

Test Plan:
- N=16, PIPE_LAT=4, rd_ready=out_ready=1, start -> stage 1 first pair (0,1) tw_idx 0; stage 4 j=1 pair (1,9) tw_idx 64; done after cycle_cnt=65 (4*(8+4)+16+1); wr_en count=32, each 4 cycles after its read.
- N=16 unload -> out_addr sequence 0,8,4,12,2,10,...,15; out_last with addr 15; IDLE the cycle after done.
- rd_ready toggling 1,0,0,1 during stage 2 -> addresses and tw_idx held while low; wr_en still exactly PIPE_LAT after each accepted pair; no pair lost or duplicated.
- cfg_log2n=0 and cfg_log2n=11 with start -> cfg_err pulse, busy stays 0; start while busy with a new cfg -> ignored, the original length completes.
- abort mid-stage 3 with two pairs in flight -> next cycle rd_valid=0, no further wr_en, busy=0, no done; a fresh start then completes normally.
- N=1024 inverse with rst asserted in UNLOAD -> all outputs 0 immediately; after release, start with N=2 -> single pair (0,1), tw_conj=0, out order 0,1, cycle_cnt=1+4+2+1=8.
